// File: rtl/argmax_pkg.sv
// argmax_pkg: shared FSM encoding, beat-count helper and the signed compare
// used by both the lane reducer and the running-max merge.
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest score supported by gt_signed; callers sign-extend into it.
    localparam int GT_W = 64;

    function automatic int beats_f(input int num_classes, input int lanes);
        return num_classes / lanes;
    endfunction

    function automatic logic gt_signed(input logic signed [GT_W-1:0] a,
                                       input logic signed [GT_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// argmax_lane_reduce: combinational LANES-wide max (plus runner-up when
// ARGMAX_MARGIN_EN is defined); ties keep the lowest index.
module argmax_lane_reduce
    import argmax_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 1,
    parameter int IDX_W  = 4
) (
    input  logic [LANES-1:0][DATA_W-1:0] lane_data,
    input  logic [IDX_W-1:0]             base_idx,
    output logic [DATA_W-1:0]            max_val,
    output logic [IDX_W-1:0]             max_idx
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0]            sec_val,
    output logic [IDX_W-1:0]             sec_idx,
    output logic                         sec_vld
`endif
);

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return gt_signed(GT_W'($signed(a)), GT_W'($signed(b)));
    endfunction

    always_comb begin
        max_val = lane_data[0];
        max_idx = base_idx;
`ifdef ARGMAX_MARGIN_EN
        sec_val = '0;
        sec_idx = '0;
        sec_vld = 1'b0;
`endif
        for (int i = 1; i < LANES; i++) begin
            if (gt(lane_data[i], max_val)) begin
`ifdef ARGMAX_MARGIN_EN
                sec_val = max_val;
                sec_idx = max_idx;
                sec_vld = 1'b1;
`endif
                max_val = lane_data[i];
                max_idx = base_idx + IDX_W'(i);
            end
`ifdef ARGMAX_MARGIN_EN
            else if (!sec_vld || gt(lane_data[i], sec_val)) begin
                sec_val = lane_data[i];
                sec_idx = base_idx + IDX_W'(i);
                sec_vld = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/argmax_stream.sv
// argmax_stream: valid/ready argmax over a NUM_CLASSES score vector, scanned
// LANES scores per cycle. Define ARGMAX_MARGIN_EN for second-index/margin ports.
module argmax_stream
    import argmax_pkg::*;
#(
    parameter  int NUM_CLASSES = 10,
    parameter  int DATA_W      = 32,
    parameter  int LANES       = 1,
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLASSES*DATA_W-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [IDX_W-1:0]              out_index,
    output logic [DATA_W-1:0]             out_score,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [IDX_W-1:0]              out_second_index,
    output logic [DATA_W-1:0]             out_margin
`endif
);

    localparam int BEATS = beats_f(NUM_CLASSES, LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (NUM_CLASSES % LANES != 0) begin : g_bad_lanes
        $error("argmax_stream: NUM_CLASSES must be a multiple of LANES");
    end
    if (NUM_CLASSES < 2 || DATA_W > GT_W) begin : g_bad_size
        $error("argmax_stream: NUM_CLASSES must be >= 2 and DATA_W <= 64");
    end

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return gt_signed(GT_W'($signed(a)), GT_W'($signed(b)));
    endfunction

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              beat_q, beat_d;
    logic [NUM_CLASSES*DATA_W-1:0] vec_q, vec_d;
    logic [DATA_W-1:0]             run_val_q, run_val_d, res_val_q, res_val_d;
    logic [IDX_W-1:0]              run_idx_q, run_idx_d, res_idx_q, res_idx_d;
    logic [LANES*DATA_W-1:0]       lane_data;
    logic [DATA_W-1:0]             beat_val, mrg_val;
    logic [IDX_W-1:0]              beat_idx, mrg_idx;
    logic                          rdy;
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0]             run_sval_q, run_sval_d, res_margin_q, res_margin_d;
    logic [IDX_W-1:0]              run_sidx_q, run_sidx_d, res_sidx_q, res_sidx_d;
    logic                          run_svld_q, run_svld_d;
    logic [DATA_W-1:0]             beat_sval, mrg_sval;
    logic [IDX_W-1:0]              beat_sidx, mrg_sidx;
    logic                          beat_svld, mrg_svld;
`endif

    always_comb begin
        lane_data = vec_q[LANES*DATA_W-1:0];
        for (int b = 1; b < BEATS; b++) begin
            if (beat_q == CNT_W'(b)) lane_data = vec_q[b*LANES*DATA_W +: LANES*DATA_W];
        end
    end

    argmax_lane_reduce #(.DATA_W(DATA_W), .LANES(LANES), .IDX_W(IDX_W)) u_reduce (
        .lane_data (lane_data),
        .base_idx  (IDX_W'(int'(beat_q) * LANES)),
        .max_val   (beat_val),
        .max_idx   (beat_idx)
`ifdef ARGMAX_MARGIN_EN
        ,
        .sec_val   (beat_sval),
        .sec_idx   (beat_sidx),
        .sec_vld   (beat_svld)
`endif
    );

    // Beat indices always exceed the running ones, so equal values never replace.
    always_comb begin
        mrg_val = run_val_q;
        mrg_idx = run_idx_q;
        if (beat_q == '0 || gt(beat_val, run_val_q)) begin
            mrg_val = beat_val;
            mrg_idx = beat_idx;
        end
`ifdef ARGMAX_MARGIN_EN
        mrg_sval = run_sval_q;
        mrg_sidx = run_sidx_q;
        mrg_svld = run_svld_q;
        if (beat_q == '0) begin
            mrg_sval = beat_sval;
            mrg_sidx = beat_sidx;
            mrg_svld = beat_svld;
        end else if (gt(beat_val, run_val_q)) begin
            mrg_svld = 1'b1;
            if (beat_svld && gt(beat_sval, run_val_q)) begin
                mrg_sval = beat_sval;
                mrg_sidx = beat_sidx;
            end else begin
                mrg_sval = run_val_q;
                mrg_sidx = run_idx_q;
            end
        end else if (!run_svld_q || gt(beat_val, run_sval_q)) begin
            mrg_sval = beat_val;
            mrg_sidx = beat_idx;
            mrg_svld = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        vec_d     = vec_q;
        run_val_d = run_val_q;
        run_idx_d = run_idx_q;
        res_val_d = res_val_q;
        res_idx_d = res_idx_q;
`ifdef ARGMAX_MARGIN_EN
        run_sval_d   = run_sval_q;
        run_sidx_d   = run_sidx_q;
        run_svld_d   = run_svld_q;
        res_sidx_d   = res_sidx_q;
        res_margin_d = res_margin_q;
`endif
        rdy = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (in_valid) begin
                    vec_d   = in_data;
                    beat_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                run_val_d = mrg_val;
                run_idx_d = mrg_idx;
`ifdef ARGMAX_MARGIN_EN
                run_sval_d = mrg_sval;
                run_sidx_d = mrg_sidx;
                run_svld_d = mrg_svld;
`endif
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    res_val_d = mrg_val;
                    res_idx_d = mrg_idx;
`ifdef ARGMAX_MARGIN_EN
                    res_sidx_d   = mrg_sidx;
                    res_margin_d = mrg_val - mrg_sval;
`endif
                    beat_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdy = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        vec_d   = in_data;
                        beat_d  = '0;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready = rdy & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            vec_q     <= '0;
            run_val_q <= '0;
            run_idx_q <= '0;
            res_val_q <= '0;
            res_idx_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            run_sval_q   <= '0;
            run_sidx_q   <= '0;
            run_svld_q   <= 1'b0;
            res_sidx_q   <= '0;
            res_margin_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            vec_q     <= vec_d;
            run_val_q <= run_val_d;
            run_idx_q <= run_idx_d;
            res_val_q <= res_val_d;
            res_idx_q <= res_idx_d;
`ifdef ARGMAX_MARGIN_EN
            run_sval_q   <= run_sval_d;
            run_sidx_q   <= run_sidx_d;
            run_svld_q   <= run_svld_d;
            res_sidx_q   <= res_sidx_d;
            res_margin_q <= res_margin_d;
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_index = res_idx_q;
    assign out_score = res_val_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_second_index = res_sidx_q;
    assign out_margin       = res_margin_q;
`endif

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Parametrised classifier back-end: accepts one vector of NUM_CLASSES signed fully-connected-layer scores per transaction, scans it LANES scores per cycle, and returns the index and value of the largest score. Sits between the final FC layer and the result display/UART path, replacing the fixed 10-class predictor with a valid/ready block of configurable class count, score width and scan parallelism.

## Interface
- NUM_CLASSES, 10, number of scores per vector (≥2)
- DATA_W, 32, score width, two's-complement signed
- LANES, 1, scores compared per scan cycle; NUM_CLASSES % LANES == 0 (elaboration error otherwise)
- IDX_W, $clog2(NUM_CLASSES), index width (derived, not overridable)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_CLASSES*DATA_W  score vector; score k at bits [k*DATA_W +: DATA_W]
- in_valid  in  1  vector present
- in_ready  out  1  block can accept a vector
- out_index  out  IDX_W  index of maximum score
- out_score  out  DATA_W  maximum score value
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1. in_valid&in_ready → capture in_data into vector register, beat counter=0, go SCAN.
- SCAN: each cycle reduce scores [beat*LANES +: LANES] and merge with running max; beat 0 seeds running max from its own lanes (no comparison with a reset constant). Counter increments; after beat BEATS-1 (BEATS=NUM_CLASSES/LANES) register result, go DONE. in_ready=0.
- DONE: out_valid=1; out_index/out_score stable until out_valid&out_ready. On handshake: if in_valid also high, capture new vector and go SCAN (in_ready = out_ready in DONE); else go IDLE.
- Comparison signed over full DATA_W; a candidate replaces current max only if strictly greater → ties resolve to lowest index, inside a beat and across beats.
- in_data ignored outside acceptance; vector register changes only on acceptance.
- rst: state IDLE, counter 0, all result regs 0, captured vector discarded, any scan in progress aborted.

## Timing
- Reset values: out_valid=0, out_index=0, out_score=0 (margin outputs 0). in_ready=0 while rst high, 1 in first cycle after rst falls.
- Latency: out_valid rises exactly BEATS clock edges after accepting edge (10 for 10/1, 5 for 10/2, 1 for LANES=NUM_CLASSES).
- Throughput: one vector per BEATS+1 cycles with out_ready held high (back-to-back accept in DONE).
- out_ready low in DONE: stall indefinitely, outputs held, in_ready=0.
- in_valid during SCAN: ignored, not queued; upstream must hold it.
- Outputs registered; in_ready combinational from state and out_ready only.

## Configuration
- ARGMAX_MARGIN_EN defined: adds ports out_second_index (IDX_W) and out_margin (DATA_W, unsigned = max − second max, exact since range ≤2^DATA_W−1). Lane reducer tracks top-2; second max is the largest score at any index other than out_index (equal values allowed, e.g. tie gives margin 0, second index = higher tied index). Same latency and handshake.
- Undefined: top-1 only, ports absent, no top-2 logic.

## Structure
- Package argmax_pkg: state enum (IDLE/SCAN/DONE), localparam function for BEATS, signed-compare helper "gt_signed" used by reducer and merge.
- One sub-module: argmax_lane_reduce — combinational LANES-wide top-1 (top-2 under ARGMAX_MARGIN_EN) reduction returning value and absolute index, lowest-index-wins; top level holds FSM, counter, vector register, running-max merge.

## Test plan
- Defaults, scores 0..9 = {3,−5,7,7,1,0,−1,2,6,4}, out_ready=1 → out_index=2, out_score=7, out_valid 10 cycles after accept; margin build: second index 3, margin 0.
- All-negative vector {−9,−2,−8,−3,…,−7} (DATA_W=32) → out_index=1, out_score=−2; confirms signed compare, no zero seed.
- LANES=5, max 0x7FFFFFFF at index 9, min 0x80000000 elsewhere → out_index=9, latency 2, margin 0xFFFFFFFF.
- out_ready low 20 cycles in DONE with in_valid high → outputs stable, in_ready=0; raise out_ready → same-cycle handshake and new-vector accept, next result after BEATS.
- rst asserted at SCAN beat 4 → next cycle out_valid=0, outputs 0, IDLE; fresh vector then gives correct result with full latency.
- Random vectors, all legal (NUM_CLASSES, LANES) pairs incl. 16/4, 3/1, random out_ready → scoreboard matches reference argmax (lowest index on ties).
